// File: rtl/result_collector_pkg.sv
// Shared definitions for the result collector: FSM encoding and default sizing.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package result_collector_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_WORDS = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        RUN   = 3'd2,
        FLUSH = 3'd3
    } state_t;

endpackage

// File: rtl/result_fifo.sv
// Generic synchronous FIFO with registered storage, wrapping pointers and occupancy count.
// Latency: a word pushed at an edge is at the head right after that edge when the FIFO was empty.
// Backpressure: push while full is dropped unless a pop happens in the same cycle.
module result_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    // Pointers wrap modulo DEPTH so non-power-of-two depths work too.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty     = (count == '0);
    assign full      = (count == CW'(DEPTH));
    assign pop_ok    = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is legal then.
    assign push_ok   = push && (!full || pop_ok);
    assign head_data = mem[rd_ptr];

    // Storage array; cleared on reset so the head reads zero out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Read/write pointers and occupancy tracking.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
            if (pop_ok)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/result_collector.sv
// Starts the wrapper, collects WORDS result words per job into a FIFO and streams them downstream.
// Latency: a word written at edge N is offered on out_valid from edge N (sampled at N+1) when the FIFO is empty.
// Backpressure: out_ready stalls the FIFO; a write into a full FIFO without a pop is dropped and flags err.
module result_collector
    import result_collector_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int WORDS = DEF_WORDS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    output logic             w_start,
    input  logic             wDone,
    input  logic             wr_req,
    input  logic [WIDTH-1:0] wr_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    input  logic             out_ready,
    output logic             busy,
    output logic             err
);

    localparam int JW = $clog2(WORDS) + 1;

    state_t                     state;
    state_t                     state_nxt;
    logic [JW-1:0]              job_cnt;
    logic                       go_ok;
    logic                       push;
    logic                       pop;
    logic                       overflow;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic [WIDTH:0]             fifo_head;
    logic [$clog2(WORDS+1)-1:0] fifo_count;

    assign go_ok    = (state == IDLE) && go && wDone;
    assign push     = (state == RUN) && wr_req;
    assign pop      = out_valid && out_ready;
    assign overflow = push && fifo_full && !pop;

    // Each entry carries a last flag alongside the data, fixed when the word is written.
    result_fifo #(
        .WIDTH (WIDTH + 1),
        .DEPTH (WORDS)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({(job_cnt == JW'(WORDS - 1)), wr_data}),
        .pop       (pop),
        .head_data (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign out_valid = !fifo_empty;
    assign out_data  = fifo_head[WIDTH-1:0];
    assign out_last  = fifo_head[WIDTH] && !fifo_empty;

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        state_nxt = state;
        w_start   = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (go_ok) state_nxt = START;
            end
            START: begin
                w_start = 1'b1;
                // Wrapper has left idle once wDone drops; release start after that.
                if (!wDone) state_nxt = RUN;
            end
            RUN: begin
                if (wr_req && (job_cnt == JW'(WORDS - 1))) state_nxt = FLUSH;
            end
            FLUSH: begin
                if ((fifo_count == '0) && wDone) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Job word counter; counts dropped words too so an overflowing job still terminates.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)       job_cnt <= '0;
        else if (go_ok) job_cnt <= '0;
        else if (push)  job_cnt <= job_cnt + JW'(1);
    end

    // Sticky error: set on overflow or stray writes, cleared only by an accepted go.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                     err <= 1'b0;
        else if (go_ok)                               err <= 1'b0;
        else if (overflow || (wr_req && state != RUN)) err <= 1'b1;
    end

endmodule

// File: tb/tb_result_collector.sv
// Directed bench for result_collector (WORDS=4 and WORDS=2 builds) and result_fifo.
// Latency: n/a.
// Backpressure: driven directly through out_ready.
module tb_result_collector;

    logic        clk;
    logic        rst;
    logic        go;
    logic        wDone;
    logic        wr_req;
    logic [15:0] wr_data;
    logic        out_ready;

    logic        d4_w_start, d4_valid, d4_last, d4_busy, d4_err;
    logic [15:0] d4_data;
    logic        d2_w_start, d2_valid, d2_last, d2_busy, d2_err;
    logic [15:0] d2_data;

    logic        f_push, f_pop, f_full, f_empty;
    logic [15:0] f_din, f_head;
    logic [1:0]  f_count;

    logic [16:0] q4[$];
    logic [16:0] q2[$];

    int n_checks = 0;
    int n_errors = 0;

    result_collector #(.WIDTH(16), .WORDS(4)) u4 (
        .clk(clk), .rst(rst), .go(go), .w_start(d4_w_start), .wDone(wDone),
        .wr_req(wr_req), .wr_data(wr_data), .out_valid(d4_valid), .out_data(d4_data),
        .out_last(d4_last), .out_ready(out_ready), .busy(d4_busy), .err(d4_err)
    );

    result_collector #(.WIDTH(16), .WORDS(2)) u2 (
        .clk(clk), .rst(rst), .go(go), .w_start(d2_w_start), .wDone(wDone),
        .wr_req(wr_req), .wr_data(wr_data), .out_valid(d2_valid), .out_data(d2_data),
        .out_last(d2_last), .out_ready(out_ready), .busy(d2_busy), .err(d2_err)
    );

    result_fifo #(.WIDTH(16), .DEPTH(2)) u_f (
        .clk(clk), .rst(rst), .push(f_push), .push_data(f_din), .pop(f_pop),
        .head_data(f_head), .full(f_full), .empty(f_empty), .count(f_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every downstream transfer; out_ready only changes just after a rising edge.
    always @(negedge clk) begin
        if (d4_valid && out_ready) q4.push_back({d4_last, d4_data});
        if (d2_valid && out_ready) q2.push_back({d2_last, d2_data});
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        q4.delete();
        q2.delete();
    endtask

    // go with wDone high, wrapper holds idle for 'hold' cycles, then drops wDone.
    task automatic start_job(input int hold);
        go = 1'b1;
        tick();
        go = 1'b0;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check("w_start_hold", d4_w_start, 1);
            tick();
        end
        wDone = 1'b0;
        @(negedge clk);
        check("w_start_before_sample", d4_w_start, 1);
        tick();
        @(negedge clk);
        check("w_start_fall", d4_w_start, 0);
        check("busy_run", d4_busy, 1);
    endtask

    task automatic push(input logic [15:0] d);
        wr_req  = 1'b1;
        wr_data = d;
        tick();
        wr_req  = 1'b0;
    endtask

    task automatic wait_idle4();
        for (int i = 0; i < 30 && d4_busy; i++) tick();
        check("idle4_timeout", d4_busy, 0);
    endtask

    task automatic wait_idle2();
        for (int i = 0; i < 30 && d2_busy; i++) tick();
        check("idle2_timeout", d2_busy, 0);
    endtask

    initial begin
        logic [15:0] bp [4];
        bp[0] = 16'h00A1; bp[1] = 16'h00A2; bp[2] = 16'h00A3; bp[3] = 16'h00A4;

        rst = 1'b1; go = 1'b0; wDone = 1'b1; wr_req = 1'b0; wr_data = '0; out_ready = 1'b0;
        f_push = 1'b0; f_pop = 1'b0; f_din = '0;
        #1 rst = 1'b0;
        #2;
        // Reset values.
        check("rst_w_start", d4_w_start, 0);
        check("rst_valid",   d4_valid,   0);
        check("rst_last",    d4_last,    0);
        check("rst_busy",    d4_busy,    0);
        check("rst_err",     d4_err,     0);
        check("rst_data",    d4_data,    0);
        check("rst_w_start2", d2_w_start, 0);
        check("rst_fifo_empty", f_empty, 1);
        tick();
        rst = 1'b1;
        tick();

        // Nominal job with downstream always ready.
        out_ready = 1'b1;
        start_job(2);
        push(16'h0011);
        @(negedge clk);
        check("lat_valid", d4_valid, 1);
        check("lat_data",  d4_data,  32'h11);
        check("lat_last",  d4_last,  0);
        push(16'h0022);
        push(16'h0033);
        push(16'h0044);
        wDone = 1'b1;
        wait_idle4();
        check("nom_count", q4.size(), 4);
        if (q4.size() == 4) begin
            check("nom_w0", q4[0], 32'h00011);
            check("nom_w1", q4[1], 32'h00022);
            check("nom_w2", q4[2], 32'h00033);
            check("nom_w3", q4[3], 32'h10044);
        end
        check("nom_err", d4_err, 0);

        // Backpressure: fill completely, then drain in consecutive cycles.
        do_reset();
        out_ready = 1'b0;
        start_job(2);
        for (int k = 0; k < 4; k++) push(bp[k]);
        @(negedge clk);
        check("bp_occupancy", u4.u_fifo.count, 4);
        check("bp_err", d4_err, 0);
        check("bp_busy", d4_busy, 1);
        wDone = 1'b1;
        tick();
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("bp_valid", d4_valid, 1);
            check("bp_data",  d4_data,  {16'h0, bp[k]});
            check("bp_last",  d4_last,  (k == 3) ? 1 : 0);
            tick();
        end
        @(negedge clk);
        check("bp_drained", d4_valid, 0);
        wait_idle4();

        // Overflow on the WORDS=2 build: third write is dropped and flags err.
        do_reset();
        out_ready = 1'b0;
        start_job(2);
        push(16'h00B1);
        push(16'h00B2);
        push(16'h00B3);
        @(negedge clk);
        check("ovf_err", d2_err, 1);
        check("ovf_occupancy", u2.u_fifo.count, 2);
        wDone = 1'b1;
        tick();
        out_ready = 1'b1;
        wait_idle2();
        check("ovf_count", q2.size(), 2);
        if (q2.size() == 2) begin
            check("ovf_w0", q2[0], 32'h000B1);
            check("ovf_w1", q2[1], 32'h100B2);
        end
        go = 1'b1;
        tick();
        go = 1'b0;
        @(negedge clk);
        check("ovf_err_clear", d2_err, 0);

        // Generic FIFO: full with simultaneous push and pop keeps occupancy and order.
        do_reset();
        f_push = 1'b1; f_din = 16'h0001; tick();
        f_din = 16'h0002; tick();
        f_push = 1'b0;
        @(negedge clk);
        check("ff_full",  f_full,  1);
        check("ff_count", f_count, 2);
        f_push = 1'b1; f_pop = 1'b1; f_din = 16'h0003;
        tick();
        f_push = 1'b0;
        @(negedge clk);
        check("ff_pp_count", f_count, 2);
        check("ff_pp_head",  f_head,  32'h2);
        tick();
        @(negedge clk);
        check("ff_pp_head2", f_head, 32'h3);
        tick();
        f_pop = 1'b0;
        @(negedge clk);
        check("ff_empty", f_empty, 1);

        // Start handshake with long wrapper idle; stray write in IDLE sets err.
        do_reset();
        wr_req = 1'b1; wr_data = 16'hDEAD;
        tick();
        wr_req = 1'b0;
        @(negedge clk);
        check("stray_err", d4_err, 1);
        check("stray_valid", d4_valid, 0);
        wDone = 1'b1;
        start_job(5);
        check("go_clears_err", d4_err, 0);

        // Reset mid-job discards buffered words.
        out_ready = 1'b0;
        push(16'h00C1);
        push(16'h00C2);
        @(negedge clk);
        check("mid_valid", d4_valid, 1);
        tick();
        rst = 1'b0;
        #1;
        check("mid_rst_valid", d4_valid, 0);
        check("mid_rst_data",  d4_data,  0);
        check("mid_rst_busy",  d4_busy,  0);
        check("mid_rst_err",   d4_err,   0);
        check("mid_rst_last",  d4_last,  0);
        tick();
        rst = 1'b1;
        wDone = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("post_rst_valid", d4_valid, 0);
            tick();
        end
        check("post_rst_busy", d4_busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
